// File: rtl/alu_pkg.sv
// Shared definitions for the two-requester ALU arbiter: command encodings,
// controller state encoding and the command type.
package alu_pkg;

   typedef logic [2:0] alu_cmd_t;

   localparam alu_cmd_t ALU_ADD  = 3'd0;
   localparam alu_cmd_t ALU_SUB  = 3'd1;
   localparam alu_cmd_t ALU_XOR  = 3'd2;
   localparam alu_cmd_t ALU_SLT  = 3'd3;
   localparam alu_cmd_t ALU_AND  = 3'd4;
   localparam alu_cmd_t ALU_NAND = 3'd5;
   localparam alu_cmd_t ALU_NOR  = 3'd6;
   localparam alu_cmd_t ALU_OR   = 3'd7;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      RESP   = 2'd2
   } state_t;

endpackage

// File: rtl/alu_rr_arbiter2.sv
// Two-way round-robin grant: a lone requester always wins, and on a tie the
// requester that did not win last time is chosen.
module alu_rr_arbiter2
   import alu_pkg::*;
(
   input  logic [1:0] valid,
   input  logic       rr_last,
   output logic [1:0] grant,
   output logic       grant_id
);

   always_comb begin
      grant_id = 1'b0;
      grant    = 2'b00;
      case (valid)
         2'b01:   grant_id = 1'b0;
         2'b10:   grant_id = 1'b1;
         2'b11:   grant_id = ~rr_last;
         default: grant_id = 1'b0;
      endcase
      if (|valid)
         grant = grant_id ? 2'b10 : 2'b01;
   end

endmodule

// File: rtl/alu_arbiter_ctrl.sv
// Shares one combinational ALU between two requesters: grants round-robin,
// holds the winner's operands for a settle window, then returns the sampled result.
module alu_arbiter_ctrl
   import alu_pkg::*;
#(
   parameter int WIDTH         = 32,
   parameter int SETTLE_CYCLES = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [2:0]       req0_cmd,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [2:0]       req1_cmd,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [WIDTH-1:0] rsp_result,
   output logic             rsp_carryout,
   output logic             rsp_overflow,
   output logic             rsp_zero,
   output logic [2:0]       alu_command,
   output logic [WIDTH-1:0] alu_operand_a,
   output logic [WIDTH-1:0] alu_operand_b,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_carryout,
   input  logic             alu_overflow,
   input  logic             alu_zero,
   output logic             busy
);

   localparam int               CNT_BITS = $clog2(SETTLE_CYCLES + 1);
   localparam int               CNT_W    = (CNT_BITS < 1) ? 1 : CNT_BITS;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

   state_t           state;
   state_t           next_state;
   logic             rr_last;
   logic [CNT_W-1:0] count;
   logic [1:0]       valid;
   logic [1:0]       grant;
   logic             grant_id;
   logic             issue;
   logic             capture;
   logic             handshake;

   // Requests are invisible while reset is held so nothing is granted during it.
   assign valid = {req1_valid, req0_valid} & {2{~reset}};

   alu_rr_arbiter2 u_arb (
      .valid    (valid),
      .rr_last  (rr_last),
      .grant    (grant),
      .grant_id (grant_id)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= IDLE;
      else
         state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (|grant) next_state = SETTLE;
         SETTLE:  if (count == '0) next_state = RESP;
         RESP:    if (rsp_valid && rsp_ready) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      busy       = 1'b1;
      issue      = 1'b0;
      capture    = 1'b0;
      handshake  = 1'b0;
      case (state)
         IDLE: begin
            req0_ready = grant[0];
            req1_ready = grant[1];
            busy       = 1'b0;
            issue      = |grant;
         end
         SETTLE:  capture   = (count == '0);
         RESP:    handshake = rsp_valid && rsp_ready;
         default: busy      = 1'b1;
      endcase
   end

   // Control: arbitration history, settle counter, response valid
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rr_last   <= 1'b1;
         count     <= '0;
         rsp_valid <= 1'b0;
      end else begin
         if (issue) begin
            rr_last <= grant_id;
            count   <= CNT_LOAD;
         end else if (state == SETTLE && count != '0) begin
            count <= count - 1'b1;
         end
         if (capture)
            rsp_valid <= 1'b1;
         else if (handshake)
            rsp_valid <= 1'b0;
      end
   end

   // ALU inputs change only on a grant edge so they stay put until the next grant
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         alu_command   <= '0;
         alu_operand_a <= '0;
         alu_operand_b <= '0;
         rsp_id        <= 1'b0;
      end else if (issue) begin
         alu_command   <= grant_id ? req1_cmd : req0_cmd;
         alu_operand_a <= grant_id ? req1_a   : req0_a;
         alu_operand_b <= grant_id ? req1_b   : req0_b;
         rsp_id        <= grant_id;
      end
   end

   // Response data is sampled once at the end of the settle window
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rsp_result   <= '0;
         rsp_carryout <= 1'b0;
         rsp_overflow <= 1'b0;
         rsp_zero     <= 1'b0;
      end else if (capture) begin
         rsp_result   <= alu_result;
         rsp_carryout <= alu_carryout;
         rsp_overflow <= alu_overflow;
         rsp_zero     <= alu_zero;
      end
   end

endmodule

// File: tb/tb_alu_arbiter_ctrl.sv
// Self-checking bench for alu_arbiter_ctrl: a delayed ALU model feeds the DUT,
// directed scenarios plus a randomized run against a transaction-level reference.
module tb_alu_arbiter_ctrl;
   import alu_pkg::*;

   localparam int W = 32;
   localparam int S = 8;

   logic clk = 1'b0;
   logic reset;

   logic         req0_valid, req0_ready, req1_valid, req1_ready;
   logic [2:0]   req0_cmd, req1_cmd;
   logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
   logic         rsp_valid, rsp_ready, rsp_id, rsp_carryout, rsp_overflow, rsp_zero;
   logic [W-1:0] rsp_result;
   logic [2:0]   alu_command;
   logic [W-1:0] alu_operand_a, alu_operand_b, alu_result;
   logic         alu_carryout, alu_overflow, alu_zero, busy;

   logic         s_req0_valid, s_req0_ready, s_req1_valid, s_req1_ready;
   logic [2:0]   s_req0_cmd, s_req1_cmd;
   logic [W-1:0] s_req0_a, s_req0_b, s_req1_a, s_req1_b;
   logic         s_rsp_valid, s_rsp_ready, s_rsp_id, s_rsp_carryout, s_rsp_overflow, s_rsp_zero;
   logic [W-1:0] s_rsp_result;
   logic [2:0]   s_alu_command;
   logic [W-1:0] s_alu_operand_a, s_alu_operand_b, s_alu_result;
   logic         s_alu_carryout, s_alu_overflow, s_alu_zero, s_busy;

   int checks;
   int fails;

   always #5 clk = ~clk;

   // Reference ALU behaviour: returns {carry, overflow, zero, result}
   function automatic logic [W+2:0] alu_eval(input logic [2:0] cmd, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
      logic signed [W-1:0] sa, sb;
      logic [W:0]          sum;
      logic [W-1:0]        r;
      logic                co, ov;
      sa = a; sb = b; co = 1'b0; ov = 1'b0; r = '0; sum = '0;
      case (cmd)
         ALU_ADD: begin
            sum = {1'b0, a} + {1'b0, b};
            r = sum[W-1:0]; co = sum[W];
            ov = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
         end
         ALU_SUB: begin
            sum = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, 1'b1};
            r = sum[W-1:0]; co = sum[W];
            ov = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
         end
         ALU_XOR:  r = a ^ b;
         ALU_SLT:  r = (sa < sb) ? W'(1) : '0;
         ALU_AND:  r = a & b;
         ALU_NAND: r = ~(a & b);
         ALU_NOR:  r = ~(a | b);
         default:  r = a | b;
      endcase
      return {co, ov, (r == '0), r};
   endfunction

   assign #3 {alu_carryout, alu_overflow, alu_zero, alu_result} =
      alu_eval(alu_command, alu_operand_a, alu_operand_b);
   assign #3 {s_alu_carryout, s_alu_overflow, s_alu_zero, s_alu_result} =
      alu_eval(s_alu_command, s_alu_operand_a, s_alu_operand_b);

   alu_arbiter_ctrl #(.WIDTH(W), .SETTLE_CYCLES(S)) dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_cmd(req0_cmd),
      .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_cmd(req1_cmd),
      .req1_a(req1_a), .req1_b(req1_b),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
      .rsp_carryout(rsp_carryout), .rsp_overflow(rsp_overflow), .rsp_zero(rsp_zero),
      .alu_command(alu_command), .alu_operand_a(alu_operand_a), .alu_operand_b(alu_operand_b),
      .alu_result(alu_result), .alu_carryout(alu_carryout), .alu_overflow(alu_overflow),
      .alu_zero(alu_zero), .busy(busy)
   );

   alu_arbiter_ctrl #(.WIDTH(W), .SETTLE_CYCLES(1)) dut_s1 (
      .clk(clk), .reset(reset),
      .req0_valid(s_req0_valid), .req0_ready(s_req0_ready), .req0_cmd(s_req0_cmd),
      .req0_a(s_req0_a), .req0_b(s_req0_b),
      .req1_valid(s_req1_valid), .req1_ready(s_req1_ready), .req1_cmd(s_req1_cmd),
      .req1_a(s_req1_a), .req1_b(s_req1_b),
      .rsp_valid(s_rsp_valid), .rsp_ready(s_rsp_ready), .rsp_id(s_rsp_id), .rsp_result(s_rsp_result),
      .rsp_carryout(s_rsp_carryout), .rsp_overflow(s_rsp_overflow), .rsp_zero(s_rsp_zero),
      .alu_command(s_alu_command), .alu_operand_a(s_alu_operand_a), .alu_operand_b(s_alu_operand_b),
      .alu_result(s_alu_result), .alu_carryout(s_alu_carryout), .alu_overflow(s_alu_overflow),
      .alu_zero(s_alu_zero), .busy(s_busy)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      repeat (2) tick();
      reset = 1'b0;
      tick();
   endtask

   function automatic logic [W-1:0] rand_word();
      case ($urandom_range(0, 5))
         0:       return '0;
         1:       return '1;
         2:       return 32'h8000_0000;
         default: return $urandom;
      endcase
   endfunction

   // Issues one op for requester id and returns what the response channel showed.
   task automatic run_op(input bit id, input logic [2:0] cmd, input logic [W-1:0] a,
                         input logic [W-1:0] b, input bit other, input int hold,
                         output int lat, output logic [W+3:0] obs, output bit busy_ok,
                         output bit stable_ok, output bit rdy_seen, output bit idle_after);
      int t;
      logic [2*W+2:0] ops;
      busy_ok = 1'b1; stable_ok = 1'b1; rdy_seen = 1'b0; t = 0;
      if (id) begin
         req1_valid = 1'b1; req1_cmd = cmd; req1_a = a; req1_b = b; req0_valid = other;
      end else begin
         req0_valid = 1'b1; req0_cmd = cmd; req0_a = a; req0_b = b; req1_valid = other;
      end
      @(negedge clk);
      while (!(id ? req1_ready : req0_ready) && t < 50) begin
         tick(); @(negedge clk); t++;
      end
      tick();
      if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
      lat = 1;
      @(negedge clk);
      ops = {alu_command, alu_operand_a, alu_operand_b};
      while (!rsp_valid && lat < 100) begin
         busy_ok &= busy;
         rdy_seen |= req0_ready | req1_ready;
         stable_ok &= (ops == {alu_command, alu_operand_a, alu_operand_b});
         tick(); lat++; @(negedge clk);
      end
      obs = {rsp_id, rsp_carryout, rsp_overflow, rsp_zero, rsp_result};
      for (int i = 0; i < hold; i++) begin
         tick(); @(negedge clk);
         busy_ok &= busy;
         rdy_seen |= req0_ready | req1_ready;
         stable_ok &= (ops == {alu_command, alu_operand_a, alu_operand_b}) && rsp_valid &&
                      (obs == {rsp_id, rsp_carryout, rsp_overflow, rsp_zero, rsp_result});
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
      @(negedge clk);
      idle_after = !busy && !rsp_valid && (ops == {alu_command, alu_operand_a, alu_operand_b});
   endtask

   task automatic test_reset();
      req0_valid = 1'b1; req1_valid = 1'b1;
      @(posedge clk); #1;
      checks++;
      if ({alu_command, alu_operand_a, alu_operand_b} !== '0) begin
         fails++; $display("FAIL reset_alu: got %h want 0", {alu_command, alu_operand_a, alu_operand_b});
      end
      checks++;
      if ({rsp_valid, rsp_id, rsp_carryout, rsp_overflow, rsp_zero, rsp_result} !== '0) begin
         fails++; $display("FAIL reset_rsp: got %h want 0", {rsp_valid, rsp_id, rsp_result});
      end
      checks++;
      if ({busy, req0_ready, req1_ready} !== 3'b000) begin
         fails++; $display("FAIL reset_ctrl: got %b want 000", {busy, req0_ready, req1_ready});
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
   endtask

   task automatic test_add();
      int lat; logic [W+3:0] obs; bit bo, so, rs, ia;
      run_op(1'b0, ALU_ADD, 32'd5, 32'd7, 1'b0, 0, lat, obs, bo, so, rs, ia);
      checks++;
      if (lat !== S + 1) begin fails++; $display("FAIL add_latency: got %0d want %0d", lat, S + 1); end
      checks++;
      if (obs !== {1'b0, 3'b000, 32'd12}) begin
         fails++; $display("FAIL add_rsp: got %h want %h", obs, {1'b0, 3'b000, 32'd12});
      end
      checks++;
      if (bo !== 1'b1) begin fails++; $display("FAIL add_busy: got %b want 1", bo); end
      checks++;
      if (ia !== 1'b1) begin fails++; $display("FAIL add_idle_after: got %b want 1", ia); end
   endtask

   task automatic test_sub();
      int lat; logic [W+3:0] obs, exp; bit bo, so, rs, ia;
      exp = {1'b1, alu_eval(ALU_SUB, 32'h8000_0000, 32'd1)};
      run_op(1'b1, ALU_SUB, 32'h8000_0000, 32'd1, 1'b0, 0, lat, obs, bo, so, rs, ia);
      checks++;
      if (obs !== exp) begin fails++; $display("FAIL sub_rsp: got %h want %h", obs, exp); end
      checks++;
      if ({obs[W+3], obs[W+1], obs[W-1:0]} !== {1'b1, 1'b1, 32'h7FFF_FFFF}) begin
         fails++; $display("FAIL sub_overflow: got %h want 1_1_7fffffff", {obs[W+3], obs[W+1], obs[W-1:0]});
      end
      checks++;
      if (so !== 1'b1) begin fails++; $display("FAIL sub_operands_stable: got %b want 1", so); end
   endtask

   task automatic test_backpressure();
      int lat; logic [W+3:0] obs, exp; bit bo, so, rs, ia;
      logic [W-1:0] a, b;
      a = $urandom; b = $urandom;
      exp = {1'b0, alu_eval(ALU_OR, a, b)};
      run_op(1'b0, ALU_OR, a, b, 1'b1, 20, lat, obs, bo, so, rs, ia);
      checks++;
      if (obs !== exp) begin fails++; $display("FAIL bp_rsp: got %h want %h", obs, exp); end
      checks++;
      if (so !== 1'b1) begin fails++; $display("FAIL bp_stable: got %b want 1", so); end
      checks++;
      if (rs !== 1'b0) begin fails++; $display("FAIL bp_ready_leak: got %b want 0", rs); end
      checks++;
      if (bo !== 1'b1) begin fails++; $display("FAIL bp_busy: got %b want 1", bo); end
      checks++;
      if (ia !== 1'b1) begin fails++; $display("FAIL bp_idle_after: got %b want 1", ia); end
   endtask

   task automatic test_alternate();
      int t; bit last, exp_id, gid;
      apply_reset();
      last = 1'b1;
      req0_valid = 1'b1; req0_cmd = ALU_SLT; req0_a = '1; req0_b = 32'd1;
      req1_valid = 1'b1; req1_cmd = ALU_SLT; req1_a = '1; req1_b = 32'd1;
      rsp_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         exp_id = ~last;
         last = exp_id;
         t = 0; @(negedge clk);
         while (!(req0_ready || req1_ready) && t < 50) begin tick(); @(negedge clk); t++; end
         gid = req1_ready;
         checks++;
         if ({req1_ready, req0_ready} !== (exp_id ? 2'b10 : 2'b01)) begin
            fails++; $display("FAIL alt_grant%0d: got %b want id %0d", k, {req1_ready, req0_ready}, exp_id);
         end
         tick();
         t = 0; @(negedge clk);
         while (!rsp_valid && t < 50) begin tick(); @(negedge clk); t++; end
         checks++;
         if ({rsp_id, rsp_result} !== {gid, 32'd1}) begin
            fails++; $display("FAIL alt_rsp%0d: got %h want %h", k, {rsp_id, rsp_result}, {gid, 32'd1});
         end
         tick();
      end
      req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
      tick();
   endtask

   task automatic test_reset_mid();
      int t, lat; bit leaked, bo, so, rs, ia; logic [W+3:0] obs;
      req0_valid = 1'b1; req0_cmd = ALU_ADD; req0_a = 32'd100; req0_b = 32'd23;
      t = 0; @(negedge clk);
      while (!req0_ready && t < 50) begin tick(); @(negedge clk); t++; end
      repeat (4) tick();
      #2 reset = 1'b1;
      #1;
      checks++;
      if ({alu_command, alu_operand_a, alu_operand_b} !== '0) begin
         fails++; $display("FAIL rmid_alu: got %h want 0", {alu_command, alu_operand_a, alu_operand_b});
      end
      checks++;
      if ({rsp_valid, rsp_id, rsp_carryout, rsp_overflow, rsp_zero, rsp_result} !== '0) begin
         fails++; $display("FAIL rmid_rsp: got %h want 0", {rsp_valid, rsp_id, rsp_result});
      end
      checks++;
      if ({busy, req0_ready, req1_ready} !== 3'b000) begin
         fails++; $display("FAIL rmid_ctrl: got %b want 000", {busy, req0_ready, req1_ready});
      end
      leaked = 1'b0;
      repeat (20) begin @(negedge clk); leaked |= rsp_valid | req0_ready | busy; end
      checks++;
      if (leaked !== 1'b0) begin fails++; $display("FAIL rmid_in_reset: got %b want 0", leaked); end
      req0_valid = 1'b0;
      tick(); reset = 1'b0; tick();
      run_op(1'b0, ALU_XOR, 32'hF0F0_F0F0, 32'hFFFF_FFFF, 1'b0, 0, lat, obs, bo, so, rs, ia);
      checks++;
      if (obs !== {1'b0, 3'b000, 32'h0F0F_0F0F}) begin
         fails++; $display("FAIL rmid_xor: got %h want %h", obs, {1'b0, 3'b000, 32'h0F0F_0F0F});
      end
   endtask

   task automatic test_settle1();
      int t, lat;
      s_req0_valid = 1'b1; s_req0_cmd = ALU_NAND; s_req0_a = '1; s_req0_b = '1; s_rsp_ready = 1'b1;
      t = 0; @(negedge clk);
      while (!s_req0_ready && t < 50) begin tick(); @(negedge clk); t++; end
      tick();
      s_req0_valid = 1'b0;
      lat = 1; @(negedge clk);
      while (!s_rsp_valid && lat < 50) begin tick(); lat++; @(negedge clk); end
      checks++;
      if (lat !== 2) begin fails++; $display("FAIL s1_latency: got %0d want 2", lat); end
      checks++;
      if ({s_rsp_id, s_rsp_zero, s_rsp_result} !== {1'b0, 1'b1, 32'd0}) begin
         fails++; $display("FAIL s1_rsp: got %h want %h", {s_rsp_id, s_rsp_zero, s_rsp_result}, {1'b0, 1'b1, 32'd0});
      end
      tick();
      s_rsp_ready = 1'b0;
   endtask

   task automatic test_random();
      bit m_idle, m_last, w;
      int m_due;
      logic [W+3:0]   m_exp;
      logic [2*W+2:0] m_ops;
      logic [1:0]     v, exp_rdy;
      apply_reset();
      m_idle = 1'b1; m_last = 1'b1; m_due = 0; m_exp = '0; m_ops = '0;
      for (int c = 0; c < 600; c++) begin
         req0_valid = 1'($urandom_range(0, 1)); req1_valid = 1'($urandom_range(0, 1));
         req0_cmd = 3'($urandom_range(0, 7)); req1_cmd = 3'($urandom_range(0, 7));
         req0_a = rand_word(); req0_b = rand_word(); req1_a = rand_word(); req1_b = rand_word();
         rsp_ready = 1'($urandom_range(0, 1));
         @(negedge clk);
         v = {req1_valid, req0_valid};
         w = (v == 2'b11) ? ~m_last : v[1];
         exp_rdy = (m_idle && v != 2'b00) ? (w ? 2'b10 : 2'b01) : 2'b00;
         checks++;
         if ({req1_ready, req0_ready} !== exp_rdy) begin
            fails++; $display("FAIL rnd_ready c%0d: got %b want %b", c, {req1_ready, req0_ready}, exp_rdy);
         end
         checks++;
         if (busy !== !m_idle) begin fails++; $display("FAIL rnd_busy c%0d: got %b want %b", c, busy, !m_idle); end
         checks++;
         if (rsp_valid !== (!m_idle && c >= m_due)) begin
            fails++; $display("FAIL rnd_rsp_valid c%0d: got %b want %b", c, rsp_valid, !m_idle && c >= m_due);
         end
         if (!m_idle) begin
            checks++;
            if ({alu_command, alu_operand_a, alu_operand_b} !== m_ops) begin
               fails++; $display("FAIL rnd_alu_in c%0d: got %h want %h", c, {alu_command, alu_operand_a, alu_operand_b}, m_ops);
            end
            if (c >= m_due) begin
               checks++;
               if ({rsp_id, rsp_carryout, rsp_overflow, rsp_zero, rsp_result} !== m_exp) begin
                  fails++; $display("FAIL rnd_rsp c%0d: got %h want %h", c, {rsp_id, rsp_carryout, rsp_overflow, rsp_zero, rsp_result}, m_exp);
               end
               if (rsp_ready) m_idle = 1'b1;
            end
         end else if (v != 2'b00) begin
            m_idle = 1'b0; m_last = w; m_due = c + S + 1;
            m_ops = w ? {req1_cmd, req1_a, req1_b} : {req0_cmd, req0_a, req0_b};
            m_exp = w ? {1'b1, alu_eval(req1_cmd, req1_a, req1_b)} : {1'b0, alu_eval(req0_cmd, req0_a, req0_b)};
         end
         tick();
      end
      req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
      repeat (S + 4) tick();
      rsp_ready = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      checks = 0; fails = 0;
      req0_valid = 1'b0; req0_cmd = '0; req0_a = '0; req0_b = '0;
      req1_valid = 1'b0; req1_cmd = '0; req1_a = '0; req1_b = '0; rsp_ready = 1'b0;
      s_req0_valid = 1'b0; s_req0_cmd = '0; s_req0_a = '0; s_req0_b = '0;
      s_req1_valid = 1'b0; s_req1_cmd = '0; s_req1_a = '0; s_req1_b = '0; s_rsp_ready = 1'b0;
      reset = 1'b1;
      test_reset();
      tick();
      reset = 1'b0;
      tick();
      test_add();
      test_sub();
      test_backpressure();
      test_alternate();
      test_reset_mid();
      test_settle1();
      test_random();
      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

endmodule

// File: doc/alu_arbiter_ctrl.md
Name: alu_arbiter_ctrl

Overview:
Shares one combinational 32-bit ALU between two requesters. The ALU supports ADD/SUB/XOR/SLT/AND/NAND/NOR/OR and has gate-level delays.
- Arbitrates round-robin between the two requesters.
- Registers the winner's command and operands onto the ALU inputs.
- Waits a programmable settle time, then captures result and flags.
- Returns them on a valid/ready response channel tagged with the requester id.

Sits between the two requesters and the ALU.

Parameters:
- WIDTH, 32, operand/result width.
- SETTLE_CYCLES, 8, cycles the ALU inputs are held stable before outputs are sampled; legal range 1..255.

Ports:
- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high reset
- req0_valid  in  1  requester 0 has an operation pending
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_cmd  in  3  requester 0 ALU command
- req0_a  in  WIDTH  requester 0 operand A
- req0_b  in  WIDTH  requester 0 operand B
- req1_valid, req1_ready, req1_cmd, req1_a, req1_b  same directions/widths as requester 0
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumer accepts
- rsp_id  out  1  requester that issued the operation
- rsp_result  out  WIDTH  captured ALU result
- rsp_carryout, rsp_overflow, rsp_zero  out  1 each  captured ALU flags
- alu_command  out  3  registered command to ALU
- alu_operand_a, alu_operand_b  out  WIDTH  registered operands to ALU
- alu_result  in  WIDTH  ALU result
- alu_carryout, alu_overflow, alu_zero  in  1 each  ALU flags
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE, rr_last=1 (requester 0 wins first tie).
  - All alu_* outputs 0; all rsp_* outputs 0; busy=0.
- FSM states: IDLE, SETTLE, RESP.
- IDLE:
  - reqN_ready is combinational: high only for the granted requester, only in IDLE.
  - Grant rule: if exactly one reqN_valid, grant it. If both, grant the one != rr_last.
  - On grant: latch cmd/a/b into alu_* regs, rsp_id<=N, rr_last<=N, counter<=SETTLE_CYCLES-1, go to SETTLE.
  - With no valid request, stay in IDLE; all regs hold.
- SETTLE:
  - If counter!=0, decrement the counter.
  - If counter==0, capture alu_result and flags into the rsp_* regs, rsp_valid<=1, go to RESP.
  - Total capture point is SETTLE_CYCLES cycles after the grant edge.
- RESP:
  - rsp_* held stable while rsp_valid && !rsp_ready.
  - On rsp_valid&&rsp_ready: rsp_valid<=0, go to IDLE. rsp data regs keep their last values.
- Operand stability: alu_* regs change only on a grant edge, so they stay constant through SETTLE and RESP.
- Latency and throughput:
  - Grant to rsp_valid is SETTLE_CYCLES+1 edges.
  - One operation per SETTLE_CYCLES+2 cycles minimum; no issue in the same cycle as a response handshake.
- Commands: all 8 encodings are legal and passed through unchanged. The block does not interpret commands.
- A requester deasserting valid before it is granted is legal; its operation is dropped silently.
- Reset mid-operation aborts: the pending response is lost, the requester is never answered, and its valid state is ignored until reset releases.
- Counter width: $clog2(SETTLE_CYCLES+1), minimum 1 bit.

Decomposition:
- Shared package alu_pkg holds:
  - command constants ADD=3'd0, SUB=1, XOR=2, SLT=3, AND=4, NAND=5, NOR=6, OR=7;
  - FSM state encoding IDLE/SETTLE/RESP;
  - alu_cmd_t 3-bit typedef.
- One natural sub-module, alu_rr_arbiter2: combinational 2-way round-robin grant from valid[1:0] and rr_last, producing grant[1:0] and grant_id.

Test Plan:
- req0 ADD a=5 b=7, rsp_ready=1, SETTLE_CYCLES=8, bench ALU model -> rsp_valid rises 9 edges after the req0_ready cycle; rsp_result=12, rsp_id=0, rsp_zero=0; busy high throughout.
- req1 SUB a=0x80000000 b=1 -> rsp_result=0x7FFFFFFF, rsp_overflow=1, rsp_id=1; alu_operand_* constant from grant to handshake.
- Both valid continuously, SLT with a=0xFFFFFFFF b=1 -> grants alternate 0,1,0,1 starting with 0; each rsp_result=1 with the matching rsp_id.
- rsp_ready held 0 for 20 cycles after rsp_valid -> rsp_* stable, req0_ready/req1_ready stay 0, busy=1; on the rsp_ready pulse, return to IDLE next cycle.
- Assert reset 3 cycles into SETTLE -> outputs 0 immediately (asynchronous), no rsp_valid; after release, a new req0 XOR 0xF0F0F0F0^0xFFFFFFFF yields 0x0F0F0F0F.
- SETTLE_CYCLES=1 build, NAND a=b=0xFFFFFFFF -> rsp_valid 2 edges after grant, rsp_result=0, rsp_zero=1.
